// File: rtl/reg_writeback_arbiter_pkg.sv
// Shared CPU constants and the register write-back entry type used by the
// write-back arbiter and its load-return FIFO.
package reg_writeback_arbiter_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 16;
  localparam int REG_COUNT  = 16;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_arbiter_if.sv
// Bundle of the ALU, load-return and register-file write signals around the
// write-back arbiter; master is the CPU side, slave is the arbiter.
interface reg_writeback_arbiter_if
  import reg_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  AluWre;
  logic [REG_ADDR_W-1:0] AluRd;
  logic [DATA_W-1:0]     AluData;
  logic                  AluStall;
  logic                  LdIssue;
  logic [REG_ADDR_W-1:0] LdIssueRd;
  logic                  LdValid;
  logic                  LdReady;
  logic [REG_ADDR_W-1:0] LdRd;
  logic [DATA_W-1:0]     LdData;
  logic                  RegWre;
  logic [REG_ADDR_W-1:0] rd;
  logic [DATA_W-1:0]     WriteData;
  logic [REG_COUNT-1:0]  Busy;
  logic [CNT_W-1:0]      FifoCount;

  modport master (
    output AluWre, AluRd, AluData, LdIssue, LdIssueRd, LdValid, LdRd, LdData,
    input  AluStall, LdReady, RegWre, rd, WriteData, Busy, FifoCount
  );

  modport slave (
    input  AluWre, AluRd, AluData, LdIssue, LdIssueRd, LdValid, LdRd, LdData,
    output AluStall, LdReady, RegWre, rd, WriteData, Busy, FifoCount
  );

endinterface

// File: rtl/reg_writeback_arbiter_wb_load_fifo.sv
// Circular buffer holding load returns until the arbiter grants them the
// register-file write port. Push into full / pop from empty are ignored.
module wb_load_fifo
  import reg_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned, which is what would infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_next(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_next(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; clearing the pointers and count
  // is enough to make stale contents unreachable.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Drives the register file's single write port from ALU results and buffered
// load returns, with starvation protection and a busy scoreboard for loads.
module reg_writeback_arbiter
  import reg_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic             CLK,
  input  logic             RST,
  reg_writeback_arbiter_if.slave wb
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SW    = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  wb_entry_t             head;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop, force_pop, alu_win;

  logic [SW-1:0]         starve_q, starve_d;
  logic                  reg_wre_q, reg_wre_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0]     write_data_q, write_data_d;
  logic [REG_COUNT-1:0]  busy_q, busy_d;

  // r0 returns complete the handshake but never occupy a slot.
  assign push = wb.LdValid && !fifo_full && (wb.LdRd != '0);

  wb_load_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK        (CLK),
    .RST        (RST),
    .push       (push),
    .push_entry ('{rd: wb.LdRd, data: wb.LdData}),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign force_pop = !fifo_empty && (starve_q == SW'(STARVE_MAX));
  assign alu_win   = !force_pop && wb.AluWre && (wb.AluRd != '0);
  assign pop       = !fifo_empty && !alu_win;

  assign wb.AluStall  = force_pop && wb.AluWre;
  assign wb.LdReady   = !fifo_full;
  assign wb.RegWre    = reg_wre_q;
  assign wb.rd        = rd_q;
  assign wb.WriteData = write_data_q;
  assign wb.Busy      = busy_q;
  assign wb.FifoCount = fifo_count;

  always_comb begin
    reg_wre_d    = alu_win || pop;
    rd_d         = rd_q;
    write_data_d = write_data_q;
    if (alu_win) begin
      rd_d         = wb.AluRd;
      write_data_d = wb.AluData;
    end else if (pop) begin
      rd_d         = head.rd;
      write_data_d = head.data;
    end

    // Only an ALU win over a waiting FIFO counts as starvation.
    if (fifo_empty || pop)                 starve_d = '0;
    else if (starve_q != SW'(STARVE_MAX))  starve_d = starve_q + 1'b1;
    else                                   starve_d = starve_q;

    // Clear before set so a same-cycle reissue of the register stays busy.
    busy_d = busy_q;
    if (pop) busy_d[head.rd] = 1'b0;
    if (wb.LdIssue && (wb.LdIssueRd != '0)) busy_d[wb.LdIssueRd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      starve_q     <= '0;
      reg_wre_q    <= 1'b0;
      rd_q         <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
    end else begin
      starve_q     <= starve_d;
      reg_wre_q    <= reg_wre_d;
      rd_q         <= rd_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: doc/reg_writeback_arbiter.md
Name: reg_writeback_arbiter

Overview:
- Write-side driver for the 16x16 CPU register file. It produces the file's single write port: `RegWre`, `rd` and `WriteData`.
- It merges two sources onto that port:
  - single-cycle ALU results;
  - multi-cycle load returns, buffered in a small FIFO.
- It keeps a busy scoreboard of registers with outstanding loads, which the hazard/stall logic consumes.

Parameters:
- `DEPTH`, 2, load-return FIFO depth (entries); must be >= 1.
- `STARVE_MAX`, 3, consecutive cycles a non-empty FIFO may lose arbitration before it is forced to win.

Ports:
- `CLK` input 1: clock; all state updates on the rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `AluWre` input 1: ALU result valid this cycle.
- `AluRd` input 4: ALU destination register.
- `AluData` input 16: ALU result.
- `AluStall` output 1: ALU write not accepted this cycle; CPU holds `AluWre`/`AluRd`/`AluData`.
- `LdIssue` input 1: a load is issued this cycle.
- `LdIssueRd` input 4: destination of the issued load.
- `LdValid` input 1: load return data valid.
- `LdReady` output 1: FIFO can accept a return; transfer occurs when `LdValid && LdReady`.
- `LdRd` input 4: load return destination.
- `LdData` input 16: load return data.
- `RegWre` output 1: register-file write enable (registered).
- `rd` output 4: register-file write address (registered).
- `WriteData` output 16: register-file write data (registered).
- `Busy` output 16: bit n=1 means register n has an outstanding load.
- `FifoCount` output `$clog2(DEPTH+1)`: current FIFO occupancy.

Behaviour:
- Reset (async, `RST`=1), all outputs and state cleared:
  - outputs: `RegWre`=0, `rd`=0, `WriteData`=0, `Busy`=0, `FifoCount`=0, `AluStall`=0, `LdReady`=1 once `RST` deasserts;
  - state: FIFO emptied (contents discarded), starve counter=0.
  - Reset mid-operation drops queued loads without writing them.
- Latency: a source accepted in cycle N appears on `RegWre`/`rd`/`WriteData` for exactly cycle N+1. `RegWre`=0 in any cycle with no accepted write.
- FIFO push:
  - `LdReady` = (`FifoCount` < `DEPTH`), from registered state only, with no combinational path from `LdValid`.
  - A return with `LdRd`=0 is accepted but not stored (r0 is hardwired zero).
- Arbitration each cycle:
  - Priority order:
    - `force` = (FIFO non-empty && starve counter == `STARVE_MAX`): pop FIFO, `AluStall`=`AluWre`.
    - else if `AluWre` && `AluRd`!=0: ALU write, `AluStall`=0.
    - else if FIFO non-empty: pop FIFO.
    - else: no write.
  - `AluWre` with `AluRd`=0: accepted (`AluStall`=0), no write emitted, and the slot is available to the FIFO the same cycle.
  - `AluStall` is combinational from `AluWre` and registered state.
- Starve counter:
  - increments when the FIFO is non-empty and the ALU wins;
  - clears on any FIFO pop or when the FIFO is empty;
  - saturates at `STARVE_MAX`.
- Simultaneous push and pop: allowed. Occupancy is unchanged, and a push into a full FIFO is still refused (`LdReady` reflects pre-pop count).
- FIFO order is strict FIFO, with wrap-around of read/write pointers modulo `DEPTH`.
- Scoreboard:
  - Set: `LdIssue` && `LdIssueRd`!=0 sets `Busy[LdIssueRd]` next edge.
  - Clear: `Busy[rd_pop]` clears on the edge where a popped FIFO entry is emitted.
  - Set and clear of the same register in the same cycle: set wins.
  - ALU write to a busy register is performed normally; `Busy` is unchanged (preventing WAW is the hazard unit's job).
  - `Busy[0]` is always 0.

Decomposition:
- Shared CPU package holds:
  - `REG_ADDR_W`=4, `DATA_W`=16, `REG_COUNT`=16;
  - typedef `wb_entry_t` {rd[3:0], data[15:0]}.
- Sub-module `wb_load_fifo` contains:
  - parameterised depth;
  - push/pop;
  - count, full, empty;
  - head output.
- Arbitration, starve counter and scoreboard stay in the top level.

Test Plan:
- ALU only: `AluWre`=1, `AluRd`=3, `AluData`=16'h1234 in cycle 0 -> cycle 1 `RegWre`=1, `rd`=3, `WriteData`=16'h1234; cycle 2 `RegWre`=0.
- Load path: `LdIssue` rd=5 -> `Busy`[5]=1 next cycle. Return rd=5, data 16'hBEEF with ALU idle -> write `rd`=5/16'hBEEF one cycle later, and `Busy`[5]=0 on that same edge.
- Starvation: FIFO holds one entry (rd=7) while `AluWre`=1 continuously with `AluRd`=2 -> three ALU writes, then the 4th cycle pops rd=7 with `AluStall`=1, then the ALU resumes.
- Full FIFO: two returns queued while ALU busy -> `LdReady`=0 and `FifoCount`=2. A third `LdValid` is held, accepted after the first pop, and write order matches arrival order.
- r0 handling: ALU write `AluRd`=0 plus a queued load rd=4 in the same cycle -> only rd=4 written; a return with `LdRd`=0 -> no write, `FifoCount` unchanged.
- Reset mid-operation: FIFO holds 2 entries and `Busy`=16'h0060, then `RST` pulses asynchronously mid-cycle -> outputs immediately 0, `FifoCount`=0, and no write of the dropped entries after release.
